// File: rtl/link_arbiter.sv
// link_arbiter: shares one outgoing link between two 4-phase Req/Ack sources.
// Round-robin grant, held for a whole packet of PKT_WORDS registered words.
//
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   S0_Req/S0_Ack/S0_Data    source 0 handshake and word
//   S1_Req/S1_Ack/S1_Data    source 1 handshake and word
//   M_Req/M_Ack/M_Data       outgoing link handshake and word
//   Grant                    one-hot current owner, 0 when idle
//   Busy                     high while a packet is in progress
module link_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_WORDS  = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  S0_Req,
    output logic                  S0_Ack,
    input  logic [DATA_WIDTH-1:0] S0_Data,
    input  logic                  S1_Req,
    output logic                  S1_Ack,
    input  logic [DATA_WIDTH-1:0] S1_Data,
    output logic                  M_Req,
    input  logic                  M_Ack,
    output logic [DATA_WIDTH-1:0] M_Data,
    output logic [1:0]            Grant,
    output logic                  Busy
);

    localparam int WW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(PKT_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEND,
        RELEASE,
        NEXT
    } state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_q, last_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  mreq_q, mreq_d;

    logic                  own_req;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  pick1;

    assign own_req  = grant_q[1] ? S1_Req : S0_Req;
    assign own_data = grant_q[1] ? S1_Data : S0_Data;
    // last_q holds the previous owner index; on a tie the other side wins.
    assign pick1    = S1_Req & (~S0_Req | ~last_q);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hold_d  = hold_q;
        mdata_d = mdata_q;
        grant_d = grant_q;
        last_d  = last_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        mreq_d  = mreq_q;
        case (state_q)
            IDLE: begin
                if (S0_Req | S1_Req) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    hold_d  = pick1 ? S1_Data : S0_Data;
                    ack0_d  = ~pick1;
                    ack1_d  = pick1;
                    wcnt_d  = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!own_req) begin
                    ack0_d  = 1'b0;
                    ack1_d  = 1'b0;
                    mdata_d = hold_q;
                    mreq_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (M_Ack) begin
                    mreq_d  = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!M_Ack) begin
                    if (wcnt_q == LAST_WORD) begin
                        grant_d = 2'b00;
                        last_d  = grant_q[1];
                        state_d = IDLE;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (own_req) begin
                    hold_d  = own_data;
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                    state_d = CAPTURE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            hold_q  <= '0;
            mdata_q <= '0;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            mreq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hold_q  <= hold_d;
            mdata_q <= mdata_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            mreq_q  <= mreq_d;
        end
    end

    assign S0_Ack = ack0_q;
    assign S1_Ack = ack1_q;
    assign M_Req  = mreq_q;
    assign M_Data = mdata_q;
    assign Grant  = grant_q;
    assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: directed tests with a packet scoreboard for link_arbiter.
// Second instance with PKT_WORDS=1 covers the single-word latency case.
module tb_link_arbiter;

    logic        clk;
    logic        rst_n;
    logic        s0_req, s1_req, m_ack;
    logic [31:0] s0_data, s1_data;
    logic        s0_ack, s1_ack, m_req, busy;
    logic [31:0] m_data;
    logic [1:0]  grant;

    logic        a_s0_req, a_s1_req, a_m_ack;
    logic [31:0] a_s0_data, a_s1_data;
    logic        a_s0_ack, a_s1_ack, a_m_req, a_busy;
    logic [31:0] a_m_data;
    logic [1:0]  a_grant;

    int          n_cmp = 0;
    int          n_err = 0;
    int          run_max = 0;
    int          stall_cfg = 0;
    logic        ds_hold = 1'b0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          owner_log[$];

    link_arbiter #(.DATA_WIDTH(32), .PKT_WORDS(2)) u_dut (
        .HCLK(clk), .HRESETn(rst_n),
        .S0_Req(s0_req), .S0_Ack(s0_ack), .S0_Data(s0_data),
        .S1_Req(s1_req), .S1_Ack(s1_ack), .S1_Data(s1_data),
        .M_Req(m_req), .M_Ack(m_ack), .M_Data(m_data),
        .Grant(grant), .Busy(busy)
    );

    link_arbiter #(.DATA_WIDTH(32), .PKT_WORDS(1)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n),
        .S0_Req(a_s0_req), .S0_Ack(a_s0_ack), .S0_Data(a_s0_data),
        .S1_Req(a_s1_req), .S1_Ack(a_s1_ack), .S1_Data(a_s1_data),
        .M_Req(a_m_req), .M_Ack(a_m_ack), .M_Data(a_m_data),
        .Grant(a_grant), .Busy(a_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL timeout %s: got no event expected handshake", nm);
    endtask

    function automatic logic ack_of(input int s);
        return (s == 0) ? s0_ack : s1_ack;
    endfunction

    task automatic set_req(input int s, input logic v, input logic [31:0] d);
        if (s == 0) begin
            s0_req = v;
            s0_data = d;
        end else begin
            s1_req = v;
            s1_data = d;
        end
    endtask

    // 4-phase source: raise Req with data, wait Ack, drop Req, wait Ack low.
    task automatic send_word(input int s, input logic [31:0] w);
        int t;
        if (s == 0) exp_q0.push_back(w);
        else exp_q1.push_back(w);
        set_req(s, 1'b1, w);
        t = 0;
        while (ack_of(s) !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout("ack_high");
        set_req(s, 1'b0, w);
        t = 0;
        while (ack_of(s) !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout("ack_low");
    endtask

    task automatic send_pkt(input int s, input logic [31:0] w0,
                            input logic [31:0] w1);
        send_word(s, w0);
        send_word(s, w1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy !== 1'b0 || m_ack !== 1'b0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout("idle");
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Downstream partner: Ack after stall_cfg cycles of M_Req, drop after M_Req.
    initial begin
        int wcnt;
        wcnt = 0;
        m_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!m_req) begin
                m_ack = 1'b0;
                wcnt = stall_cfg;
            end else if (!m_ack && !ds_hold) begin
                if (wcnt > 0) wcnt--;
                else m_ack = 1'b1;
            end
        end
    end

    // Scoreboard: every word leaving the link must be the next word its owner
    // sent, packets are never interleaved, and the link word stays stable.
    initial begin
        logic        pm;
        logic [31:0] pd;
        int          pc, co, own, run;
        logic [31:0] e;
        pm = 1'b0;
        pd = '0;
        pc = 0;
        co = 0;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q0.delete();
                exp_q1.delete();
                pm = 1'b0;
                pc = 0;
                run = 0;
            end else begin
                chk("busy_vs_grant", 32'(busy), 32'(grant != 2'b00));
                chk("grant_onehot", 32'(grant == 2'b11), 32'd0);
                chk("s0_ack_owner", 32'(s0_ack & ~grant[0]), 32'd0);
                chk("s1_ack_owner", 32'(s1_ack & ~grant[1]), 32'd0);
                if (m_req) chk("ack_in_send", 32'(s0_ack | s1_ack), 32'd0);
                if (m_req && pm) chk("mdata_stable", m_data, pd);
                if (m_req && !pm) begin
                    chk("mreq_granted", 32'(grant != 2'b00), 32'd1);
                    own = grant[1] ? 1 : 0;
                    if (pc != 0) chk("pkt_atomic", 32'(own), 32'(co));
                    co = own;
                    if (own == 0 && exp_q0.size() != 0) begin
                        e = exp_q0.pop_front();
                        chk("word_s0", m_data, e);
                    end else if (own == 1 && exp_q1.size() != 0) begin
                        e = exp_q1.pop_front();
                        chk("word_s1", m_data, e);
                    end else begin
                        chk("unexpected_word", m_data, 32'hFFFF_FFFF);
                    end
                    pc++;
                    if (pc == 2) begin
                        owner_log.push_back(own);
                        pc = 0;
                    end
                end
                if (pc != 0 && !m_req) chk("busy_mid_pkt", 32'(busy), 32'd1);
                run = m_req ? run + 1 : 0;
                if (run > run_max) run_max = run;
                pm = m_req;
                pd = m_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        rst_n = 1'b0;
        s0_req = 1'b0; s1_req = 1'b0;
        s0_data = '0; s1_data = '0;
        a_s0_req = 1'b0; a_s1_req = 1'b0; a_m_ack = 1'b0;
        a_s0_data = '0; a_s1_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_s0_ack", 32'(s0_ack), 32'd0);
        chk("rst_s1_ack", 32'(s1_ack), 32'd0);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst1_grant", 32'(a_grant), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: single word packet on the PKT_WORDS=1 instance.
        a_s0_data = 32'h7;
        a_s0_req = 1'b1;
        @(negedge clk);
        chk("t1_ack", 32'(a_s0_ack), 32'd1);
        chk("t1_grant", 32'(a_grant), 32'd1);
        chk("t1_busy", 32'(a_busy), 32'd1);
        chk("t1_mreq_early", 32'(a_m_req), 32'd0);
        a_s0_req = 1'b0;
        @(negedge clk);
        chk("t1_mreq", 32'(a_m_req), 32'd1);
        chk("t1_mdata", a_m_data, 32'h7);
        chk("t1_ack_low", 32'(a_s0_ack), 32'd0);
        a_m_ack = 1'b1;
        @(negedge clk);
        chk("t1_mreq_low", 32'(a_m_req), 32'd0);
        chk("t1_grant_rel", 32'(a_grant), 32'd1);
        a_m_ack = 1'b0;
        @(negedge clk);
        chk("t1_grant_end", 32'(a_grant), 32'd0);
        chk("t1_busy_end", 32'(a_busy), 32'd0);

        // Test 2: two-word packet from S1.
        send_pkt(1, 32'h0001_0000, 32'h0000_000A);
        wait_idle();
        chk("t2_pkts", 32'(owner_log.size()), 32'd1);
        chk("t2_owner", 32'(owner_log[0]), 32'd1);
        chk("t2_drained", 32'(exp_q1.size()), 32'd0);

        // Test 3: simultaneous requests after reset; S0 first.
        apply_reset();
        base = owner_log.size();
        fork
            send_pkt(0, 32'hA000_0000, 32'hA000_0001);
            send_pkt(1, 32'hB000_0000, 32'hB000_0001);
        join
        wait_idle();
        chk("t3_pkts", 32'(owner_log.size() - base), 32'd2);
        chk("t3_first", 32'(owner_log[base]), 32'd0);
        chk("t3_second", 32'(owner_log[base+1]), 32'd1);

        // Test 4: both request continuously; owners alternate.
        base = owner_log.size();
        fork
            begin
                send_pkt(0, 32'hC000_0000, 32'hC000_0001);
                send_pkt(0, 32'hC000_0002, 32'hC000_0003);
            end
            begin
                send_pkt(1, 32'hD000_0000, 32'hD000_0001);
                send_pkt(1, 32'hD000_0002, 32'hD000_0003);
            end
        join
        wait_idle();
        chk("t4_pkts", 32'(owner_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_owner%0d", i), 32'(owner_log[base+i]),
                32'(i % 2));

        // Test 5: downstream stalls 50 cycles per word.
        stall_cfg = 50;
        base = owner_log.size();
        send_pkt(0, 32'h5555_0000, 32'h5555_0001);
        wait_idle();
        stall_cfg = 0;
        chk("t5_run", 32'(run_max), 32'd51);
        chk("t5_pkts", 32'(owner_log.size() - base), 32'd1);
        chk("t5_drained", 32'(exp_q0.size()), 32'd0);

        // Test 6: reset asserted while the first word is in SEND.
        ds_hold = 1'b1;
        exp_q0.push_back(32'hDEAD_0001);
        s0_data = 32'hDEAD_0001;
        s0_req = 1'b1;
        t = 0;
        while (s0_ack !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("t6_ack");
        s0_req = 1'b0;
        t = 0;
        while (m_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("t6_mreq");
        @(negedge clk);
        chk("t6_in_send", 32'(m_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_mreq", 32'(m_req), 32'd0);
        chk("t6_acks", 32'({s0_ack, s1_ack}), 32'd0);
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_mdata", m_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ds_hold = 1'b0;
        @(negedge clk);
        base = owner_log.size();
        send_pkt(1, 32'h1111_0000, 32'h1111_0001);
        wait_idle();
        chk("t6_pkts", 32'(owner_log.size() - base), 32'd1);
        chk("t6_owner", 32'(owner_log[base]), 32'd1);
        chk("end_q0", 32'(exp_q0.size()), 32'd0);
        chk("end_q1", 32'(exp_q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
